result_tx: RTL
==============

RESULT_TX -- requirements
Module: result_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter HEADER, default 16'hBAFD, meaning the FPGA-to-PC response packet header.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port start_i, input, 1 bit: request valid.
REQ-006 The block SHALL have port result_i, input, 64 bits: the addition result to send.
REQ-007 The block SHALL have port ready_o, output, 1 bit: the block is idle and can accept a request.
REQ-008 The block SHALL have port tx_o, output, 1 bit: UART serial line, 8N1.
REQ-009 The block SHALL have port busy_o, output, 1 bit: a packet is in transmission.
REQ-010 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when a packet completes.

Function
REQ-011 A request SHALL be accepted on any cycle where start_i=1 and ready_o=1; result_i SHALL be captured in that cycle.
REQ-012 start_i while ready_o=0 SHALL be ignored, with no queuing; result_i changes after acceptance SHALL NOT affect the packet.
REQ-013 The packet SHALL be 11 bytes, sent in this order:
- HEADER[7:0] (0xFD), then HEADER[15:8] (0xBA)
- result[7:0] through result[63:56]: 8 bytes, least-significant first
- checksum
REQ-014 The checksum SHALL be (HEADER + result) mod 256, which equals (HEADER[7:0] + result[7:0]) mod 256; it SHALL be computed from the captured value.
REQ-015 Each byte SHALL be framed as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); each bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-016 Consecutive bytes SHALL follow with no idle gap: the start bit of byte n+1 SHALL begin the cycle after the stop bit of byte n ends.
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP:
- IDLE->START on acceptance
- START->DATA after CLKS_PER_BIT cycles
- DATA->STOP after 8 bits
- STOP->START if bytes remain, else STOP->IDLE
REQ-018 tx_o SHALL go low the cycle after acceptance; in IDLE and STOP, tx_o SHALL be 1.
REQ-019 Total packet duration SHALL be 110*CLKS_PER_BIT cycles, measured from the first start-bit cycle to the last stop-bit cycle inclusive.
REQ-020 On the cycle after the last stop-bit cycle, done_o SHALL be 1 for exactly one cycle and ready_o SHALL return to 1.
REQ-021 A new start_i in that same cycle SHALL be accepted, giving back-to-back packets separated only by that one idle-high cycle.
REQ-022 busy_o SHALL equal NOT ready_o at all times.
REQ-023 The bit counter (0..7), byte counter (0..10) and baud counter (0..CLKS_PER_BIT-1) SHALL wrap to 0 at their terminal counts and never exceed them.
REQ-024 Internal arithmetic SHALL be at least 9 bits wide before the mod-256 truncation, so the carry out of the checksum addition is discarded cleanly.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL set:
- tx_o=1, ready_o=1, busy_o=0, done_o=0
- FSM=IDLE
- all counters and the captured result = 0
REQ-026 Reset asserted mid-packet SHALL abort the packet: tx_o=1 from the next cycle, no done_o pulse, and no resumption after reset is released.
REQ-027 start_i SHALL be ignored while rst_n=0.

Verification (CLKS_PER_BIT=4)
REQ-028 Nominal packet: result_i=64'd25 with start_i pulse -> byte stream FD BA 19 00 00 00 00 00 00 00 16; done_o pulses exactly 440 cycles after the first start-bit cycle begins.
REQ-029 Checksum carry: result_i=64'hFFFF_FFFF_FFFF_FFFF -> data bytes FF x8, checksum 0xFC; result_i=0 -> checksum 0xFD.
REQ-030 Back-to-back packets:
- start_i held high with result_i=64'd1 then 64'd2 -> two packets with checksums 0xFE and 0xFF
- the second packet's start bit occurs 2 cycles after the first packet's last stop-bit cycle (1 idle-high cycle between them)
REQ-031 Busy ignore: start_i pulsed with result_i=64'hAA during byte 5 -> current packet unchanged, no second packet, exactly one done_o pulse.
REQ-032 Mid-packet reset: rst_n=0 for 1 cycle during DATA of byte 3 -> tx_o=1 and ready_o=1 the following cycle, no done_o; a subsequent request with result_i=64'd25 produces the REQ-028 stream exactly.
REQ-033 Bit timing: every tx_o level change in REQ-028 occurs on a multiple of 4 cycles from the first start-bit edge, and the line stays 1 throughout IDLE.

Source files
------------

// File: rtl/result_tx.sv
// UART transmitter for the 11-byte FPGA-to-PC result packet: header, 8 result bytes LSB first, checksum.
// One request is captured while idle; bytes are sent 8N1 back to back with no idle gap between them.
//
//   state   | meaning
//   --------+----------------------------------------------
//   S_IDLE  | line high, ready for a request
//   S_START | start bit (0) of the current byte
//   S_DATA  | 8 data bits of the current byte, LSB first
//   S_STOP  | stop bit (1); next byte or back to idle
module result_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [15:0] HEADER       = 16'hBAFD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [63:0] result_i,
    output logic        ready_o,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'd7;
    localparam logic [3:0]        LAST_BYTE = 4'd10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic [BAUD_W-1:0] baud_q,   baud_d;
    logic [2:0]        bit_q,    bit_d;
    logic [3:0]        byte_q,   byte_d;
    logic [63:0]       result_q, result_d;
    logic [7:0]        chk_q,    chk_d;
    logic              done_q,   done_d;

    logic [8:0]        chk_sum;
    logic [7:0]        cur_byte;
    logic              baud_tc;

    // Only the low header byte and low result byte reach the low 8 bits of the sum.
    assign chk_sum = {1'b0, HEADER[7:0]} + {1'b0, result_i[7:0]};
    assign baud_tc = (baud_q == BAUD_LAST);

    always_comb begin
        cur_byte = chk_q;
        case (byte_q)
            4'd0:    cur_byte = HEADER[7:0];
            4'd1:    cur_byte = HEADER[15:8];
            4'd2:    cur_byte = result_q[7:0];
            4'd3:    cur_byte = result_q[15:8];
            4'd4:    cur_byte = result_q[23:16];
            4'd5:    cur_byte = result_q[31:24];
            4'd6:    cur_byte = result_q[39:32];
            4'd7:    cur_byte = result_q[47:40];
            4'd8:    cur_byte = result_q[55:48];
            4'd9:    cur_byte = result_q[63:56];
            default: cur_byte = chk_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        result_d = result_q;
        chk_d    = chk_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_START;
                    baud_d   = '0;
                    bit_d    = '0;
                    byte_d   = '0;
                    result_d = result_i;
                    chk_d    = 8'(chk_sum);
                end
            end
            S_START: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    baud_d = '0;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    baud_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        byte_d  = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            result_q <= '0;
            chk_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            result_q <= result_d;
            chk_q    <= chk_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            S_START: tx_o = 1'b0;
            S_DATA:  tx_o = cur_byte[bit_q];
            default: tx_o = 1'b1;
        endcase
    end

    assign ready_o = (state_q == S_IDLE);
    assign busy_o  = ~ready_o;
    assign done_o  = done_q;

endmodule
